// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory read port, execute redirect and decode handshake.
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_unit_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        imem_valid_in;
    logic [31:0] imem_data_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        inst_valid_out;
    logic        inst_ready_in;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        fault_out;

    modport master (
        output imem_req_out, imem_addr_out, inst_valid_out, instruction_out, pc_out, fault_out,
        input  imem_ready_in, imem_valid_in, imem_data_in, redirect_valid_in, redirect_pc_in,
               inst_ready_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out, inst_valid_out, instruction_out, pc_out, fault_out,
        output imem_ready_in, imem_valid_in, imem_data_in, redirect_valid_in, redirect_pc_in,
               inst_ready_in
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem reads, credit-limited instruction buffer with PC tags,
// redirect flush with stale-response dropping, and halt on misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned BUF_DEPTH       = 2
) (
    input logic          clk_in,
    input logic          rst_in,
    fetch_unit_if.master bus
);
    localparam int unsigned BW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] out_q, out_d, out_after;
    logic [OW-1:0] drop_q, drop_d;
    logic [31:0]   buf_inst_q [BUF_DEPTH];
    logic [31:0]   buf_inst_d [BUF_DEPTH];
    logic [31:0]   buf_pc_q   [BUF_DEPTH];
    logic [31:0]   buf_pc_d   [BUF_DEPTH];
    logic [BW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d;
    logic [31:0]   tag_q [MAX_OUTSTANDING];
    logic [31:0]   tag_d [MAX_OUTSTANDING];
    logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic          req_q, req_d, valid_q, valid_d, fault_q, fault_d;
    logic [31:0]   inst_q, inst_d, pc_q, pc_d;
    logic          accept, pop, push;

    function automatic logic [BW-1:0] buf_inc(input logic [BW-1:0] p);
        return (32'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        accept     = req_q & bus.imem_ready_in;
        pop        = valid_q & bus.inst_ready_in;
        push       = 1'b0;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        buf_rd_d   = buf_rd_q;
        buf_wr_d   = buf_wr_q;
        tag_d      = tag_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        out_after  = out_q + OW'(accept) - OW'(bus.imem_valid_in);
        out_d      = out_after;

        if (accept) begin
            fetch_pc_d      = fetch_pc_q + 32'd4;
            tag_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d        = tag_inc(tag_wr_q);
        end
        if (bus.imem_valid_in) begin
            if (drop_q != '0) begin
                drop_d = drop_q - 1'b1;
            end else begin
                push                 = 1'b1;
                buf_inst_d[buf_wr_q] = bus.imem_data_in;
                buf_pc_d[buf_wr_q]   = tag_q[tag_rd_q];
                buf_wr_d             = buf_inc(buf_wr_q);
                tag_rd_d             = tag_inc(tag_rd_q);
            end
        end
        if (pop) begin
            buf_rd_d = buf_inc(buf_rd_q);
        end
        buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);

        if (state_q == StFlush && drop_d == '0) begin
            state_d = StRun;
        end

        // Everything still in flight after this cycle belongs to the old path.
        if (bus.redirect_valid_in) begin
            fetch_pc_d = bus.redirect_pc_in;
            drop_d     = out_after;
            buf_cnt_d  = '0;
            buf_rd_d   = '0;
            buf_wr_d   = '0;
            tag_rd_d   = '0;
            tag_wr_d   = '0;
            if (bus.redirect_pc_in[1:0] != 2'b00) begin
                state_d = StHalt;
            end else if (out_after != '0) begin
                state_d = StFlush;
            end else begin
                state_d = StRun;
            end
        end

        req_d = (state_d == StRun) && !bus.redirect_valid_in &&
                ((32'(out_d) + 32'(buf_cnt_d)) < BUF_DEPTH) && (32'(out_d) < MAX_OUTSTANDING);
        valid_d = (buf_cnt_d != '0);
        fault_d = (state_d == StHalt);
        if (buf_cnt_d != '0) begin
            inst_d = buf_inst_d[buf_rd_d];
            pc_d   = buf_pc_d[buf_rd_d];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            buf_rd_q   <= '0;
            buf_wr_q   <= '0;
            buf_cnt_q  <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            inst_q     <= 32'h0000_0013;
            pc_q       <= RESET_PC;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_inst_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            buf_rd_q   <= buf_rd_d;
            buf_wr_q   <= buf_wr_d;
            buf_cnt_q  <= buf_cnt_d;
            tag_q      <= tag_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
        end
    end

    assign bus.imem_req_out    = req_q;
    assign bus.imem_addr_out   = fetch_pc_q;
    assign bus.inst_valid_out  = valid_q;
    assign bus.instruction_out = inst_q;
    assign bus.pc_out          = pc_q;
    assign bus.fault_out       = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: imem model with random latency plus a stream-level reference
// (expected PC sequence, in-flight/stale/buffered counts) checked every cycle.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          MAXO     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC       (RESET_PC),
        .MAX_OUTSTANDING(MAXO),
        .BUF_DEPTH      (DEPTH)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference: in-flight reads in issue order, words delivered but not consumed, expected streams.
    logic [31:0] q_addr[$];
    int          q_due[$];
    bit          q_stale[$];
    int          buffered, consumed, cyc;
    logic [31:0] issue_pc, exp_pc;
    bit          fault_m, redir_prev;
    int          rdy_pct, dec_pct, lat_max;
    bit          redir_req, redir_on_collide, collide_hit;
    logic [31:0] redir_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic model_reset();
        q_addr.delete();
        q_due.delete();
        q_stale.delete();
        buffered   = 0;
        issue_pc   = RESET_PC;
        exp_pc     = RESET_PC;
        fault_m    = 1'b0;
        redir_prev = 1'b1;
    endtask

    task automatic drive_idle();
        bus.imem_ready_in     = 1'b0;
        bus.imem_valid_in     = 1'b0;
        bus.imem_data_in      = '0;
        bus.inst_ready_in     = 1'b0;
        bus.redirect_valid_in = 1'b0;
        bus.redirect_pc_in    = '0;
    endtask

    task automatic check_reset_values(input string tag);
        compared += 6;
        if (bus.imem_req_out !== 1'b0) begin
            mismatched++; $display("FAIL %s req got=%b exp=0", tag, bus.imem_req_out);
        end
        if (bus.imem_addr_out !== RESET_PC) begin
            mismatched++; $display("FAIL %s addr got=%h exp=%h", tag, bus.imem_addr_out, RESET_PC);
        end
        if (bus.inst_valid_out !== 1'b0) begin
            mismatched++; $display("FAIL %s valid got=%b exp=0", tag, bus.inst_valid_out);
        end
        if (bus.instruction_out !== 32'h0000_0013) begin
            mismatched++; $display("FAIL %s inst got=%h exp=00000013", tag, bus.instruction_out);
        end
        if (bus.pc_out !== RESET_PC) begin
            mismatched++; $display("FAIL %s pc got=%h exp=%h", tag, bus.pc_out, RESET_PC);
        end
        if (bus.fault_out !== 1'b0) begin
            mismatched++; $display("FAIL %s fault got=%b exp=0", tag, bus.fault_out);
        end
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance the reference to the next edge.
    task automatic tick();
        int          stale_n, sz;
        bit          req_exp, rdy, mv, dr, rv, hs, acc, st;
        logic [31:0] rp, a;
        stale_n = 0;
        foreach (q_stale[i]) if (q_stale[i]) stale_n++;
        sz      = q_addr.size();
        req_exp = !redir_prev && !fault_m && stale_n == 0 && (sz + buffered < DEPTH) && sz < MAXO;
        compared += 3;
        if (bus.imem_req_out !== req_exp) begin
            mismatched++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, bus.imem_req_out, req_exp);
        end
        if (bus.inst_valid_out !== (buffered != 0)) begin
            mismatched++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, bus.inst_valid_out, buffered != 0);
        end
        if (bus.fault_out !== fault_m) begin
            mismatched++; $display("FAIL fault cyc=%0d got=%b exp=%b", cyc, bus.fault_out, fault_m);
        end
        if (bus.imem_req_out === 1'b1 && !fault_m) begin
            compared++;
            if (bus.imem_addr_out !== issue_pc) begin
                mismatched++;
                $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr_out, issue_pc);
            end
        end

        rdy = ($urandom_range(99) < rdy_pct);
        mv  = (sz > 0) && (q_due[0] <= cyc);
        dr  = ($urandom_range(99) < dec_pct);
        rv  = redir_req;
        rp  = redir_pc;
        if (redir_on_collide && mv && bus.inst_valid_out === 1'b1 && dr) begin
            rv = 1'b1; collide_hit = 1'b1; redir_on_collide = 1'b0;
        end
        bus.imem_ready_in     = rdy;
        bus.imem_valid_in     = mv;
        bus.imem_data_in      = mv ? mem_word(q_addr[0]) : $urandom;
        bus.inst_ready_in     = dr;
        bus.redirect_valid_in = rv;
        bus.redirect_pc_in    = rv ? rp : $urandom;

        hs = (bus.inst_valid_out === 1'b1) && dr;
        if (hs) begin
            compared += 2;
            if (bus.pc_out !== exp_pc) begin
                mismatched++; $display("FAIL pc_out cyc=%0d got=%h exp=%h", cyc, bus.pc_out, exp_pc);
            end
            if (bus.instruction_out !== mem_word(exp_pc)) begin
                mismatched++;
                $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, bus.instruction_out,
                         mem_word(exp_pc));
            end
            exp_pc += 32'd4;
            consumed++;
            if (buffered > 0) buffered--;
        end
        acc = (bus.imem_req_out === 1'b1) && rdy;
        if (mv) begin
            a  = q_addr.pop_front();
            sz = q_due.pop_front();
            st = q_stale.pop_front();
            if (!st && !rv) buffered++;
        end
        if (acc) begin
            q_addr.push_back(issue_pc);
            q_due.push_back(cyc + 1 + int'($urandom_range(lat_max, 0)));
            q_stale.push_back(1'b0);
            issue_pc += 32'd4;
        end
        if (rv) begin
            foreach (q_stale[i]) q_stale[i] = 1'b1;
            buffered = 0;
            issue_pc = rp;
            exp_pc   = rp;
            fault_m  = (rp[1:0] != 2'b00);
        end
        redir_prev = rv;
        redir_req  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (consumed < target && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (consumed < target) begin
            mismatched++; $display("FAIL %s timeout consumed=%0d need=%0d", tag, consumed, target);
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_req = 1'b1;
        redir_pc  = pc;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
    endtask

    task automatic test_stream();
        rdy_pct = 100; dec_pct = 100; lat_max = 0;
        run_until(consumed + 8, 80, "stream");
    endtask

    task automatic test_stall();
        int c0;
        rdy_pct = 100; dec_pct = 0; lat_max = 1;
        repeat (10) tick();
        compared += 3;
        if (bus.imem_req_out !== 1'b0) begin
            mismatched++; $display("FAIL stall_req got=%b exp=0", bus.imem_req_out);
        end
        if (bus.inst_valid_out !== 1'b1) begin
            mismatched++; $display("FAIL stall_valid got=%b exp=1", bus.inst_valid_out);
        end
        if (buffered != DEPTH) begin
            mismatched++; $display("FAIL stall_held got=%0d exp=%0d", buffered, DEPTH);
        end
        c0 = consumed;
        dec_pct = 100;
        run_until(c0 + 4, 40, "stall_drain");
    endtask

    task automatic test_redirect();
        int n, c0;
        rdy_pct = 100; dec_pct = 100; lat_max = 3;
        n = 0;
        while (q_addr.size() != 2 && n < 60) begin
            tick();
            n++;
        end
        compared++;
        if (q_addr.size() != 2) begin
            mismatched++; $display("FAIL redir_setup outstanding=%0d exp=2", q_addr.size());
        end
        redirect(32'h0000_0100);
        c0 = consumed;
        run_until(c0 + 2, 60, "redir_resume");
    endtask

    task automatic test_collide();
        int n, c0;
        rdy_pct = 100; dec_pct = 100; lat_max = 0;
        redir_on_collide = 1'b1;
        redir_pc         = 32'h0000_0300;
        collide_hit      = 1'b0;
        n = 0;
        while (!collide_hit && n < 60) begin
            tick();
            n++;
        end
        redir_on_collide = 1'b0;
        compared++;
        if (!collide_hit) begin
            mismatched++; $display("FAIL collide_setup got=0 exp=1");
        end
        c0 = consumed;
        run_until(c0 + 3, 60, "collide_resume");
    endtask

    task automatic test_fault();
        int c0;
        rdy_pct = 80; dec_pct = 100; lat_max = 2;
        redirect(32'h0000_0102);
        repeat (10) tick();
        compared += 2;
        if (bus.fault_out !== 1'b1) begin
            mismatched++; $display("FAIL halt_fault got=%b exp=1", bus.fault_out);
        end
        if (bus.imem_req_out !== 1'b0) begin
            mismatched++; $display("FAIL halt_req got=%b exp=0", bus.imem_req_out);
        end
        redirect(32'h0000_0200);
        c0 = consumed;
        run_until(c0 + 2, 60, "halt_resume");
        compared++;
        if (bus.fault_out !== 1'b0) begin
            mismatched++; $display("FAIL resume_fault got=%b exp=0", bus.fault_out);
        end
    endtask

    task automatic test_wrap_and_reset();
        int c0;
        rdy_pct = 100; dec_pct = 100; lat_max = 1;
        redirect(32'hFFFF_FFF8);
        c0 = consumed;
        run_until(c0 + 3, 60, "wrap");
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        drive_idle();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c0 = consumed;
        run_until(c0 + 2, 40, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] t;
        rdy_pct = 70; dec_pct = 60; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            if ((fault_m && $urandom_range(99) < 20) || (!fault_m && $urandom_range(99) < 5)) begin
                t = $urandom & 32'hFFFF_FFFC;
                if (!fault_m && $urandom_range(9) == 0) t[0] = 1'b1;
                redir_req = 1'b1;
                redir_pc  = t;
            end
            tick();
        end
        if (fault_m) redirect(32'h0000_0400);
        dec_pct = 100;
        run_until(consumed + 3, 80, "random_tail");
    endtask

    initial begin
        consumed = 0; cyc = 0;
        rdy_pct = 100; dec_pct = 100; lat_max = 0;
        redir_req = 1'b0; redir_on_collide = 1'b0; collide_hit = 1'b0; redir_pc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_collide();
        test_fault();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
